// File: rtl/seg_display_mux.sv
// Four-digit common-anode seven-segment scan multiplexer.
// Snapshots the digit bus once per frame and blanks digits selected by
// blink_mask on alternate blink phases.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses a leading zero
// on digit 3 when that digit is not being adjusted.
module seg_display_mux #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_2hz,
    input  logic [3:0] hex3,
    input  logic [3:0] hex2,
    input  logic [3:0] hex1,
    input  logic [3:0] hex0,
    input  logic [3:0] blink_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            phase_q, phase_d;
    logic [3:0]      sh3_q, sh2_q, sh1_q;
    logic [3:1]      sh_mask_q;  // slot 0 always uses the live mask bit
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick;
    logic            snap;
    logic [3:0]      slot_hex;
    logic            slot_mbit;
    logic            blank;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == CntMax);
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;

    // Next-state: refresh counter, scan index, blink phase and the slot being entered.
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        snap      = tick && (idx_d == 2'd0);
        phase_d   = phase_q;
        slot_hex  = hex0;
        slot_mbit = blink_mask[0];
        an_d      = an_q;
        seg_d     = seg_q;
        dp_d      = dp_q;

        // Leaving adjust mode clears the phase so digits come back immediately.
        if (blink_mask == 4'd0) begin
            phase_d = 1'b0;
        end else if (en_2hz) begin
            phase_d = ~phase_q;
        end

        // Digit 0 is decoded from the live bus, the same value being snapshotted.
        unique case (idx_d)
            2'd0: begin slot_hex = hex0;  slot_mbit = blink_mask[0]; end
            2'd1: begin slot_hex = sh1_q; slot_mbit = sh_mask_q[1];  end
            2'd2: begin slot_hex = sh2_q; slot_mbit = sh_mask_q[2];  end
            default: begin slot_hex = sh3_q; slot_mbit = sh_mask_q[3]; end
        endcase

        // Pre-toggle phase is used when tick and en_2hz coincide.
        blank = slot_mbit & phase_q;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if ((idx_d == 2'd3) && (sh3_q == 4'd0) && !sh_mask_q[3]) begin
            blank = 1'b1;
        end
`endif

        if (tick) begin
            if (blank) begin
                an_d  = 4'b1111;
                seg_d = 7'h7F;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = decode(slot_hex);
                dp_d  = (idx_d != 2'd2);
            end
        end
    end

    // State and registered outputs; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd3;
            phase_q   <= 1'b0;
            sh3_q     <= 4'd0;
            sh2_q     <= 4'd0;
            sh1_q     <= 4'd0;
            sh_mask_q <= 3'd0;
            an_q      <= 4'b1111;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            if (snap) begin
                sh3_q     <= hex3;
                sh2_q     <= hex2;
                sh1_q     <= hex1;
                sh_mask_q <= blink_mask[3:1];
            end
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed self-checking bench for seg_display_mux with REFRESH_DIV=4.
module tb_seg_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_2hz = 1'b0;
    logic [3:0] hex3 = 4'd1;
    logic [3:0] hex2 = 4'd2;
    logic [3:0] hex1 = 4'd3;
    logic [3:0] hex0 = 4'd4;
    logic [3:0] blink_mask = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_err = 0;

    seg_display_mux #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_2hz     (en_2hz),
        .hex3       (hex3),
        .hex2       (hex2),
        .hex1       (hex1),
        .hex0       (hex0),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp);
        n_cmp++;
        assert ({an, seg, dp} === {e_an, e_seg, e_dp}) else begin
            n_err++;
            $error("FAIL %s: observed an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                   tag, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    initial begin
        #12;
        chk("reset_state", 4'b1111, 7'h7F, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic scan
        step(3); chk("blank_before_first_tick", 4'b1111, 7'h7F, 1'b1);
        step(1); chk("slot0_4", 4'b1110, 7'h19, 1'b1);
        step(4); chk("slot1_3", 4'b1101, 7'h30, 1'b1);
        step(4); chk("slot2_2_dp", 4'b1011, 7'h24, 1'b0);
        step(4); chk("slot3_1", 4'b0111, 7'h79, 1'b1);
        step(4); chk("frame2_slot0_4", 4'b1110, 7'h19, 1'b1);

        // Mid-frame changes held off until next frame
        step(4); chk("f2_slot1_3", 4'b1101, 7'h30, 1'b1);
        hex0 = 4'd7; hex1 = 4'd5; hex2 = 4'd8;
        step(4); chk("f2_slot2_shadow", 4'b1011, 7'h24, 1'b0);
        step(4); chk("f2_slot3_shadow", 4'b0111, 7'h79, 1'b1);
        step(4); chk("f3_slot0_7", 4'b1110, 7'h78, 1'b1);
        step(4); chk("f3_slot1_5", 4'b1101, 7'h12, 1'b1);
        step(4); chk("f3_slot2_8", 4'b1011, 7'h00, 1'b0);
        step(4); chk("f3_slot3_1", 4'b0111, 7'h79, 1'b1);

        // Blink digits 0 and 1
        blink_mask = 4'b0011; en_2hz = 1'b1;
        step(1); en_2hz = 1'b0;
        step(3); chk("blink_slot0_blank", 4'b1111, 7'h7F, 1'b1);
        step(4); chk("blink_slot1_blank", 4'b1111, 7'h7F, 1'b1);
        step(4); chk("blink_slot2_shown", 4'b1011, 7'h00, 1'b0);
        step(4); chk("blink_slot3_shown", 4'b0111, 7'h79, 1'b1);
        en_2hz = 1'b1;
        step(1); en_2hz = 1'b0;
        step(3); chk("unblink_slot0", 4'b1110, 7'h78, 1'b1);
        step(4); chk("unblink_slot1", 4'b1101, 7'h12, 1'b1);

        // Blink digits 2/3, then leave adjust mode mid-slot
        blink_mask = 4'b1100; en_2hz = 1'b1;
        step(1); en_2hz = 1'b0;
        step(3); chk("m1100_slot2_old_shadow", 4'b1011, 7'h00, 1'b0);
        step(4); chk("m1100_slot3_old_shadow", 4'b0111, 7'h79, 1'b1);
        step(4); chk("m1100_slot0_shown", 4'b1110, 7'h78, 1'b1);
        step(4); chk("m1100_slot1_shown", 4'b1101, 7'h12, 1'b1);
        step(4); chk("m1100_slot2_blank", 4'b1111, 7'h7F, 1'b1);
        blink_mask = 4'b0000;
        step(1);
        step(3); chk("mask_clear_slot3_visible", 4'b0111, 7'h79, 1'b1);
        step(4); chk("mc_slot0", 4'b1110, 7'h78, 1'b1);
        step(4); chk("mc_slot1", 4'b1101, 7'h12, 1'b1);
        step(4); chk("mc_slot2", 4'b1011, 7'h00, 1'b0);

        // Asynchronous reset mid-slot
        step(1);
        #2 rst = 1'b0;
        #1 chk("async_reset_midslot", 4'b1111, 7'h7F, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        step(3); chk("post_reset_blank", 4'b1111, 7'h7F, 1'b1);
        step(1); chk("post_reset_slot0", 4'b1110, 7'h78, 1'b1);

        // Leading zero on digit 3
        hex3 = 4'd0;
        step(4); chk("lz_slot1", 4'b1101, 7'h12, 1'b1);
        step(4); chk("lz_slot2", 4'b1011, 7'h00, 1'b0);
        step(4); chk("lz_slot3_shadow_1", 4'b0111, 7'h79, 1'b1);
        step(4);
        step(12);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("lz_slot3_suppressed", 4'b1111, 7'h7F, 1'b1);
`else
        chk("lz_slot3_zero", 4'b0111, 7'h40, 1'b1);
`endif
        blink_mask = 4'b1000;
        step(16); chk("lz_masked_slot3_zero", 4'b0111, 7'h40, 1'b1);
        en_2hz = 1'b1;
        step(1); en_2hz = 1'b0;
        step(15); chk("lz_masked_slot3_blink", 4'b1111, 7'h7F, 1'b1);
        blink_mask = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
